// File: rtl/axi_wr_arbiter_if.sv
// axi_wr_arbiter_if: AXI write-channel widths plus the bundle joining NM requesters, the arbiter and one downstream slave
package axi_pkg;
    localparam int AXI_IW     = 4;
    localparam int AXI_AW     = 32;
    localparam int AXI_LW     = 8;
    localparam int AXI_SW     = 3;
    localparam int AXI_BURSTW = 2;
    localparam int AXI_DW     = 32;
    localparam int AXI_WSTRBW = AXI_DW / 8;
    localparam int AXI_BRESPW = 2;
endpackage

interface axi_wr_arbiter_if #(parameter int NM = 2);
    import axi_pkg::*;
    logic [NM-1:0][AXI_IW-1:0]     s_awid;
    logic [NM-1:0][AXI_AW-1:0]     s_awaddr;
    logic [NM-1:0][AXI_LW-1:0]     s_awlen;
    logic [NM-1:0][AXI_SW-1:0]     s_awsize;
    logic [NM-1:0][AXI_BURSTW-1:0] s_awburst;
    logic [NM-1:0]                 s_awvalid;
    logic [NM-1:0]                 s_awready;
    logic [NM-1:0][AXI_DW-1:0]     s_wdata;
    logic [NM-1:0][AXI_WSTRBW-1:0] s_wstrb;
    logic [NM-1:0]                 s_wlast;
    logic [NM-1:0]                 s_wvalid;
    logic [NM-1:0]                 s_wready;
    logic [NM-1:0][AXI_IW-1:0]     s_bid;
    logic [NM-1:0][AXI_BRESPW-1:0] s_bresp;
    logic [NM-1:0]                 s_bvalid;
    logic [NM-1:0]                 s_bready;
    logic [AXI_IW-1:0]             m_awid;
    logic [AXI_AW-1:0]             m_awaddr;
    logic [AXI_LW-1:0]             m_awlen;
    logic [AXI_SW-1:0]             m_awsize;
    logic [AXI_BURSTW-1:0]         m_awburst;
    logic                          m_awvalid;
    logic                          m_awready;
    logic [AXI_DW-1:0]             m_wdata;
    logic [AXI_WSTRBW-1:0]         m_wstrb;
    logic                          m_wlast;
    logic                          m_wvalid;
    logic                          m_wready;
    logic [AXI_IW-1:0]             m_bid;
    logic [AXI_BRESPW-1:0]         m_bresp;
    logic                          m_bvalid;
    logic                          m_bready;

    modport slave (
        input  s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
        output s_awready,
        input  s_wdata, s_wstrb, s_wlast, s_wvalid,
        output s_wready,
        output s_bid, s_bresp, s_bvalid,
        input  s_bready,
        output m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        input  m_awready,
        output m_wdata, m_wstrb, m_wlast, m_wvalid,
        input  m_wready,
        input  m_bid, m_bresp, m_bvalid,
        output m_bready
    );

    modport master (
        output s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
        input  s_awready,
        output s_wdata, s_wstrb, s_wlast, s_wvalid,
        input  s_wready,
        input  s_bid, s_bresp, s_bvalid,
        output s_bready,
        input  m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        output m_awready,
        input  m_wdata, m_wstrb, m_wlast, m_wvalid,
        output m_wready,
        output m_bid, m_bresp, m_bvalid,
        input  m_bready
    );
endinterface

// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: round-robin share of one AXI write path (AW/W/B) among NM requesters, one burst in flight
module axi_wr_arbiter
    import axi_pkg::*;
#(
    parameter  int NM    = 2,
    localparam int GNT_W = $clog2(NM)
) (
    input  logic             aclk,
    input  logic             aresetn,
    axi_wr_arbiter_if.slave  bus,
    output logic [GNT_W-1:0] gnt_idx,
    output logic             busy,
    output logic             wlast_err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t            state, state_n;
    logic [GNT_W-1:0]  gnt, win, rr_ptr, k;
    logic [AXI_LW-1:0] len_q, beat_cnt;
    logic              any_req, aw_hs, w_hs, b_hs;

    // lowest offset from rr_ptr wins, so scan offsets downward and let the last hit stand
    always_comb begin
        win = rr_ptr;
        k = '0;
        for (int i = NM - 1; i >= 0; i--) begin
            k = GNT_W'((int'(rr_ptr) + i) % NM);
            if (bus.s_awvalid[k]) win = k;
        end
    end

    assign any_req = |bus.s_awvalid;
    assign aw_hs   = bus.m_awvalid && bus.m_awready;
    assign w_hs    = bus.m_wvalid && bus.m_wready;
    assign b_hs    = bus.m_bvalid && bus.m_bready;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = any_req ? ADDR : IDLE;
            ADDR:    state_n = aw_hs ? DATA : ADDR;
            DATA:    state_n = (w_hs && bus.m_wlast) ? RESP : DATA;
            default: state_n = b_hs ? IDLE : RESP;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= IDLE;
            gnt       <= '0;
            rr_ptr    <= '0;
            len_q     <= '0;
            beat_cnt  <= '0;
            wlast_err <= 1'b0;
        end else begin
            state     <= state_n;
            wlast_err <= w_hs && (bus.s_wlast[gnt] != bus.m_wlast);
            if (state == IDLE && any_req) gnt <= win;
            if (aw_hs) len_q <= bus.s_awlen[gnt];
            if (aw_hs) beat_cnt <= '0;
            else if (w_hs) beat_cnt <= beat_cnt + AXI_LW'(1);
            if (b_hs) rr_ptr <= (gnt == GNT_W'(NM - 1)) ? '0 : gnt + GNT_W'(1);
        end
    end

    // only the owner sees ready/valid; everyone else stays quiet
    always_comb begin
        bus.s_awready      = '0;
        bus.s_wready       = '0;
        bus.s_bvalid       = '0;
        bus.s_bid          = '0;
        bus.s_bresp        = '0;
        bus.s_awready[gnt] = state == ADDR && bus.m_awready;
        bus.s_wready[gnt]  = state == DATA && bus.m_wready;
        bus.s_bvalid[gnt]  = state == RESP && bus.m_bvalid;
        bus.s_bid[gnt]     = bus.m_bid;
        bus.s_bresp[gnt]   = bus.m_bresp;
    end

    assign bus.m_awid    = bus.s_awid[gnt];
    assign bus.m_awaddr  = bus.s_awaddr[gnt];
    assign bus.m_awlen   = bus.s_awlen[gnt];
    assign bus.m_awsize  = bus.s_awsize[gnt];
    assign bus.m_awburst = bus.s_awburst[gnt];
    assign bus.m_awvalid = state == ADDR && bus.s_awvalid[gnt];
    assign bus.m_wdata   = bus.s_wdata[gnt];
    assign bus.m_wstrb   = bus.s_wstrb[gnt];
    assign bus.m_wlast   = state == DATA && beat_cnt == len_q;
    assign bus.m_wvalid  = state == DATA && bus.s_wvalid[gnt];
    assign bus.m_bready  = state == RESP && bus.s_bready[gnt];
    assign gnt_idx       = gnt;
    assign busy          = state != IDLE;
endmodule
